data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface data_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;
    logic          err0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          lock1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;
    logic          err1;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0, err0,
        input  req1, we1, addr1, wdata1, lock1,
        output gnt1, rvalid1, rdata1, err1,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0, err0,
        output req1, we1, addr1, wdata1, lock1,
        input  gnt1, rvalid1, rdata1, err1,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared data memory: CPU port 0 has fixed priority,
// loader port 1 gets a starvation guard and a burst lock; out-of-range addresses are flagged.
module data_mem_arbiter #(
    parameter int DEPTH    = 128,
    parameter int MAX_WAIT = 4,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_arbiter_if.slave    bus
);
    localparam int            WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);
    localparam logic [AW-1:0]  DEPTH_C    = AW'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           win_q, win_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           locked_q, locked_d;
    logic           cmd_we_q, cmd_we_d;
    logic [AW-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic           err_pend_q, err_pend_d;

    logic           win0, win1;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           access;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            win_q       <= 1'b0;
            wait_q      <= '0;
            locked_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            wait_q      <= wait_d;
            locked_q    <= locked_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_pend_q  <= err_pend_d;
        end
    end

    always_comb begin
        // Port 1 overrides port 0 when locked, starved, or uncontested.
        win1      = bus.req1 && (locked_q || (wait_q == MAX_WAIT_C) || !bus.req0);
        win0      = !win1 && bus.req0;
        sel_we    = win1 ? bus.we1    : bus.we0;
        sel_addr  = win1 ? bus.addr1  : bus.addr0;
        sel_wdata = win1 ? bus.wdata1 : bus.wdata0;

        state_d     = state_q;
        win_d       = win_q;
        wait_d      = wait_q;
        locked_d    = locked_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_pend_d  = err_pend_q;

        case (state_q)
            S_IDLE: begin
                if (win1 || win0) begin
                    state_d     = S_ACCESS;
                    win_d       = win1;
                    cmd_we_d    = sel_we;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    err_pend_d  = (sel_addr >= DEPTH_C);
                end
                if (win1) begin
                    wait_d = '0;
                end else if (win0 && bus.req1 && (wait_q != MAX_WAIT_C)) begin
                    wait_d = wait_q + WCW'(1);
                end
                // The lock survives only while port 1 keeps asking with lock1 set.
                locked_d = win1 && bus.lock1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        access        = (state_q == S_ACCESS);
        bus.gnt0      = access && !win_q;
        bus.gnt1      = access && win_q;
        bus.mem_we    = access && cmd_we_q && !err_pend_q;
        bus.mem_addr  = access ? cmd_addr_q  : '0;
        bus.mem_wdata = access ? cmd_wdata_q : '0;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic          done;
        logic          rvalid_q, rvalid_d;
        logic          err_q, err_d;
        logic [DW-1:0] rdata_q, rdata_d;

        always_comb begin
            done     = (state_q == S_ACCESS) && ((gi == 1) ? win_q : !win_q);
            rvalid_d = done;
            err_d    = done ? err_pend_q : err_q;
            rdata_d  = rdata_q;
            if (done) begin
                rdata_d = (!cmd_we_q && !err_pend_q) ? bus.mem_rdata : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                err_q    <= err_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign bus.rvalid0 = g_port[0].rvalid_q;
    assign bus.rdata0  = g_port[0].rdata_q;
    assign bus.err0    = g_port[0].err_q;
    assign bus.rvalid1 = g_port[1].rvalid_q;
    assign bus.rdata1  = g_port[1].rdata_q;
    assign bus.err1    = g_port[1].err_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules and a shadow copy of the memory.
module tb_data_mem_arbiter;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int DEPTH    = 128;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    data_mem_arbiter #(
        .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write at the clock edge.
    logic [DW-1:0] ram [0:DEPTH-1] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = ram[bus.mem_addr[6:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.lock1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.mem_we} !== 7'b0 ||
                bus.rdata0 !== 16'h0 || bus.rdata1 !== 16'h0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: gnt=%b%b rvalid=%b%b err=%b%b mem_we=%b addr=%h wdata=%h rdata0=%h rdata1=%h, required all zero",
                         c, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.mem_we,
                         bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt0=%b gnt1=%b, required gnt0=1 gnt1=0", bus.gnt0, bus.gnt1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== 16'h0 || bus.err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_rvalid: rvalid0=%b rvalid1=%b rdata0=%h err0=%b, required 1 0 0000 0",
                     bus.rvalid0, bus.rvalid1, bus.rdata0, bus.err0);
        end
        $display("txn reset: released, first grant to port 0 and completion checked");
    endtask

    task automatic test_write_read();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd5; bus.wdata0 = 16'hBEEF;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'd5 || bus.mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_access: gnt0=%b mem_we=%b mem_addr=%h mem_wdata=%h, required 1 1 0005 beef",
                     bus.gnt0, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.mem_we !== 1'b0 || bus.err0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_complete: rvalid0=%b mem_we=%b err0=%b, required 1 0 0", bus.rvalid0, bus.mem_we, bus.err0);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd5;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_access: gnt0=%b mem_we=%b, required 1 0", bus.gnt0, bus.mem_we);
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'hBEEF || bus.err0 !== 1'b0) begin
            errors++;
            $display("FAIL rd_complete: rvalid0=%b rdata0=%h err0=%b, required 1 beef 0", bus.rvalid0, bus.rdata0, bus.err0);
        end
        $display("txn write_read: port 0 wrote beef to 5 and read it back");
    endtask

    task automatic test_fairness();
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 16'd1;
        bus.req1 = 1'b1; bus.addr1 = 16'd2;
        for (int i = 0; i < 10; i++) begin
            bit exp1;
            exp1 = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {~exp1, exp1}) begin
                errors++;
                $display("FAIL fairness_grant %0d: gnt0=%b gnt1=%b, required gnt0=%b gnt1=%b",
                         i, bus.gnt0, bus.gnt1, ~exp1, exp1);
            end
            $display("txn fairness decision %0d: gnt0=%b gnt1=%b", i, bus.gnt0, bus.gnt1);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.we1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.addr1  = 16'(10 + k);
            bus.wdata1 = 16'(16'hA000 + k);
            tick();
            checks++;
            if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'(10 + k)) begin
                errors++;
                $display("FAIL lock_burst %0d: gnt1=%b gnt0=%b mem_we=%b mem_addr=%h, required 1 0 1 %h",
                         k, bus.gnt1, bus.gnt0, bus.mem_we, bus.mem_addr, 16'(10 + k));
            end
            if (k == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd3;
            end
            if (k == 2) begin
                bus.req1 = 1'b0; bus.lock1 = 1'b0;
            end
            tick();
        end
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
        end
        bus.req0 = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ram[10 + k] !== 16'(16'hA000 + k)) begin
                errors++;
                $display("FAIL lock_mem %0d: mem=%h, required %h", 10 + k, ram[10 + k], 16'(16'hA000 + k));
            end
        end
        $display("txn lock: 3-write burst on port 1, port 0 granted after release");
    endtask

    task automatic test_out_of_range();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd72; bus.wdata0 = 16'h1234;
        tick();
        bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd5;
        tick();
        bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd200; bus.wdata0 = 16'hFFFF;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd200) begin
            errors++;
            $display("FAIL oor_access: gnt0=%b mem_we=%b mem_addr=%h, required 1 0 00c8", bus.gnt0, bus.mem_we, bus.mem_addr);
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.err0 !== 1'b1 || bus.rdata0 !== 16'h0) begin
            errors++;
            $display("FAIL oor_complete: rvalid0=%b err0=%b rdata0=%h, required 1 1 0000", bus.rvalid0, bus.err0, bus.rdata0);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd72;
        tick();
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 16'h1234 || bus.err0 !== 1'b0) begin
            errors++;
            $display("FAIL oor_alias_read: rvalid0=%b rdata0=%h err0=%b, required 1 1234 0", bus.rvalid0, bus.rdata0, bus.err0);
        end
        $display("txn out_of_range: write to 200 suppressed, address 72 intact");
    endtask

    task automatic test_reset_mid_access();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd10;
        tick();
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: gnt1=%b, required 1", bus.gnt1);
        end
        reset = 1'b1;
        bus.req1 = 1'b0;
        tick();
        checks++;
        if (bus.rvalid1 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.rdata1 !== 16'h0) begin
            errors++;
            $display("FAIL midrst_read: rvalid1=%b gnt1=%b gnt0=%b rdata1=%h, required 0 0 0 0000",
                     bus.rvalid1, bus.gnt1, bus.gnt0, bus.rdata1);
        end
        reset = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd20; bus.wdata0 = 16'h5555;
        tick();
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (ram[20] !== 16'h5555 || bus.rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_write: mem[20]=%h rvalid0=%b, required 5555 0", ram[20], bus.rvalid0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_idle: gnt=%b%b rvalid=%b%b, required all zero", bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1);
        end
        $display("txn reset_mid_access: read dropped, in-flight write landed");
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, 65535));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic test_random();
        // Transaction-level model of the arbiter and a shadow memory image.
        bit            m_busy, m_win, m_locked, m_we;
        int            m_wait;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic [DW-1:0] shadow [DEPTH];
        bit            m_rvalid [2];
        bit            m_err    [2];
        logic [DW-1:0] m_rdata  [2];
        bit            p_req    [2];
        bit            p_we     [2];
        logic [AW-1:0] p_addr   [2];
        logic [DW-1:0] p_wdata  [2];
        bit            p_lock;
        int            n_done;

        do_reset();
        for (int a = 0; a < DEPTH; a++) shadow[a] = ram[a];
        m_busy = 0; m_win = 0; m_locked = 0; m_we = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; p_lock = 0; n_done = 0;
        for (int p = 0; p < 2; p++) begin
            m_rvalid[p] = 0; m_err[p] = 0; m_rdata[p] = '0;
            p_req[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wdata[p] = '0;
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            bit            e_g0, e_g1, e_we;
            logic [AW-1:0] e_addr;
            bit            w0, w1;
            e_g0   = m_busy && !m_win;
            e_g1   = m_busy && m_win;
            e_we   = m_busy && m_we && (int'(m_addr) < DEPTH);
            e_addr = m_busy ? m_addr : '0;

            checks++;
            if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_addr, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.rdata0, bus.rdata1} !==
                {e_g0, e_g1, e_we, e_addr, m_rvalid[0], m_rvalid[1], m_err[0], m_err[1], m_rdata[0], m_rdata[1]}) begin
                errors++;
                $display("FAIL random cycle %0d: gnt=%b%b we=%b addr=%h rv=%b%b err=%b%b rd=%h/%h, required gnt=%b%b we=%b addr=%h rv=%b%b err=%b%b rd=%h/%h",
                         cyc, bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_addr, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1,
                         bus.rdata0, bus.rdata1, e_g0, e_g1, e_we, e_addr, m_rvalid[0], m_rvalid[1], m_err[0], m_err[1],
                         m_rdata[0], m_rdata[1]);
            end

            // Requesters: drop or replace on grant, hold otherwise, sometimes start anew.
            for (int p = 0; p < 2; p++) begin
                if ((p == 0 && e_g0) || (p == 1 && e_g1)) p_req[p] = 0;
                if (!p_req[p] && $urandom_range(0, 2) != 0) begin
                    p_req[p]   = 1;
                    p_we[p]    = $urandom_range(0, 1) != 0;
                    p_addr[p]  = rand_addr();
                    p_wdata[p] = DW'($urandom);
                    if (p == 1) p_lock = $urandom_range(0, 3) == 0;
                end
            end
            bus.req0 = p_req[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wdata[0];
            bus.req1 = p_req[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wdata[1];
            bus.lock1 = p_req[1] && p_lock;

            if (m_busy) begin
                for (int p = 0; p < 2; p++) m_rvalid[p] = (p == int'(m_win));
                m_err[m_win]   = int'(m_addr) >= DEPTH;
                m_rdata[m_win] = (!m_we && int'(m_addr) < DEPTH) ? shadow[m_addr[6:0]] : '0;
                if (m_we && int'(m_addr) < DEPTH) shadow[m_addr[6:0]] = m_wdata;
                m_busy = 0;
                n_done++;
            end else begin
                m_rvalid[0] = 0;
                m_rvalid[1] = 0;
                w1 = bus.req1 && (m_locked || m_wait == MAX_WAIT || !bus.req0);
                w0 = !w1 && bus.req0;
                if (w1) m_wait = 0;
                else if (w0 && bus.req1 && m_wait < MAX_WAIT) m_wait++;
                if (w1 && bus.lock1) m_locked = 1;
                else if (!(bus.req1 && bus.lock1)) m_locked = 0;
                if (w0 || w1) begin
                    m_busy  = 1;
                    m_win   = w1;
                    m_we    = w1 ? bus.we1    : bus.we0;
                    m_addr  = w1 ? bus.addr1  : bus.addr0;
                    m_wdata = w1 ? bus.wdata1 : bus.wdata0;
                end
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        $display("txn random: 600 cycles, %0d accesses completed", n_done);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_fairness();
        test_lock();
        test_out_of_range();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
